usb_frame_arbiter: RTL and testbench



---
 rtl/usb_frame_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_usb_frame_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_frame_arbiter.sv
// ============================================================================
//  Module   : usb_frame_arbiter
//  Purpose  : Round-robin, frame-granular sharing of one USB byte stream with
//             inter-frame gap, idle timeout and length cap. Optional source-0
//             absolute priority when USB_ARB_PRIO0_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module usb_frame_arbiter #(
    parameter int NB_SRC     = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64,
    parameter int MAX_BYTES  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_SRC-1:0]     req_i,
    input  logic [NB_SRC-1:0]     frame_i,
    input  logic [NB_SRC-1:0]     valid_i,
    input  logic [NB_SRC*8-1:0]   data_i,
    output logic [NB_SRC-1:0]     gnt_o,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    output logic                  frame_o,
    output logic                  abort_o,
    output logic                  trunc_o
);

    localparam int SELW = $clog2(NB_SRC);
    localparam int BCW  = $clog2(MAX_BYTES + 1);
    localparam int TCW  = $clog2(TIMEOUT + 1);
    localparam int GCW  = $clog2(GAP_CYCLES + 1);

    localparam logic [BCW-1:0] c_MAXB  = BCW'(MAX_BYTES);
    localparam logic [TCW-1:0] c_TLAST = TCW'(TIMEOUT - 1);
    localparam logic [GCW-1:0] c_GLAST = GCW'(GAP_CYCLES - 1);

`ifdef USB_ARB_PRIO0_EN
    localparam bit c_PRIO0 = 1'b1;
`else
    localparam bit c_PRIO0 = 1'b0;
`endif

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] c_ST_XFER     = 2'd2;
    localparam logic [1:0] c_ST_GAP      = 2'd3;

    logic [1:0]      r_state;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_rr;
    logic [BCW-1:0]  r_bcnt;
    logic [TCW-1:0]  r_tcnt;
    logic [GCW-1:0]  r_gcnt;
    logic            r_dropped;

    logic            w_frm;
    logic            w_vld;
    logic [7:0]      w_dat;
    logic            w_byte;
    logic            w_any;
    logic [SELW-1:0] w_win;
    int              w_idx;

    always_comb begin
        w_frm = 1'b0;
        w_vld = 1'b0;
        w_dat = 8'h00;
        for (int k = 0; k < NB_SRC; k++) begin
            if (r_sel == k[SELW-1:0]) begin
                w_frm = frame_i[k];
                w_vld = valid_i[k];
                w_dat = data_i[k*8 +: 8];
            end
        end
    end

    assign w_byte = w_vld & w_frm;

    // Round-robin search starting after r_rr; in priority mode source 0 is
    // excluded from the rotation and overrides it whenever it requests.
    always_comb begin
        w_any = 1'b0;
        w_win = r_rr;
        w_idx = 0;
        for (int i = 1; i <= NB_SRC; i++) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= NB_SRC) begin
                w_idx = w_idx - NB_SRC;
            end
            if (!w_any && req_i[w_idx] && !(c_PRIO0 && w_idx == 0)) begin
                w_any = 1'b1;
                w_win = w_idx[SELW-1:0];
            end
        end
        if (c_PRIO0 && req_i[0]) begin
            w_any = 1'b1;
            w_win = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_ST_IDLE;
            r_sel     <= '0;
            r_rr      <= SELW'(NB_SRC - 1);
            r_bcnt    <= '0;
            r_tcnt    <= '0;
            r_gcnt    <= '0;
            r_dropped <= 1'b0;
            gnt_o     <= '0;
            data_o    <= 8'h00;
            valid_o   <= 1'b0;
            frame_o   <= 1'b0;
            abort_o   <= 1'b0;
            trunc_o   <= 1'b0;
        end else begin
            abort_o <= 1'b0;
            trunc_o <= 1'b0;
            valid_o <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        gnt_o        <= '0;
                        gnt_o[w_win] <= 1'b1;
                        r_sel        <= w_win;
                        if (!(c_PRIO0 && w_win == '0)) begin
                            r_rr <= w_win;
                        end
                        r_tcnt    <= '0;
                        r_bcnt    <= '0;
                        r_dropped <= 1'b0;
                        r_state   <= c_ST_WAIT_SOF;
                    end
                end
                c_ST_WAIT_SOF, c_ST_XFER: begin
                    if (r_state == c_ST_XFER && !w_frm) begin
                        // Normal end wins over a coincident timeout.
                        frame_o <= 1'b0;
                        gnt_o   <= '0;
                        r_gcnt  <= '0;
                        r_state <= c_ST_GAP;
                    end else begin
                        if (r_state == c_ST_WAIT_SOF && w_frm) begin
                            frame_o <= 1'b1;
                            r_state <= c_ST_XFER;
                        end
                        if (w_byte) begin
                            r_tcnt <= '0;
                            if (r_bcnt < c_MAXB) begin
                                valid_o <= 1'b1;
                                data_o  <= w_dat;
                                r_bcnt  <= r_bcnt + 1'b1;
                            end else if (!r_dropped) begin
                                trunc_o   <= 1'b1;
                                r_dropped <= 1'b1;
                            end
                        end else if (r_tcnt == c_TLAST) begin
                            abort_o <= 1'b1;
                            frame_o <= 1'b0;
                            gnt_o   <= '0;
                            r_gcnt  <= '0;
                            r_state <= c_ST_GAP;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                c_ST_GAP: begin
                    if (r_gcnt == c_GLAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_frame_arbiter.sv
// ============================================================================
//  Module   : tb_usb_frame_arbiter
//  Purpose  : Directed self-checking bench for usb_frame_arbiter (default
//             parameters; priority section active with USB_ARB_PRIO0_EN).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_usb_frame_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [3:0]  frame_i;
    logic [3:0]  valid_i;
    logic [31:0] data_i;
    logic [3:0]  gnt_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        frame_o;
    logic        abort_o;
    logic        trunc_o;

    int checks   = 0;
    int failures = 0;

    usb_frame_arbiter #(
        .NB_SRC     (4),
        .GAP_CYCLES (2),
        .TIMEOUT    (64),
        .MAX_BYTES  (64)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .frame_i (frame_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .gnt_o   (gnt_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .frame_o (frame_o),
        .abort_o (abort_o),
        .trunc_o (trunc_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame from an already-granted source and checks the stream.
    task automatic run_frame(input int src, input int nbytes, input int base);
        frame_i[src] = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            valid_i[src] = 1'b1;
            data_i[src*8 +: 8] = 8'(base + k);
            tick();
            chk("frame_hi", {31'd0, frame_o}, 32'd1);
            if (k < 64) begin
                chk("valid_fwd", {31'd0, valid_o}, 32'd1);
                chk("data_fwd", {24'd0, data_o}, {24'd0, 8'(base + k)});
            end else begin
                chk("valid_drop", {31'd0, valid_o}, 32'd0);
                chk("trunc", {31'd0, trunc_o}, (k == 64) ? 32'd1 : 32'd0);
            end
        end
        frame_i[src] = 1'b0;
        valid_i[src] = 1'b0;
        tick();
        chk("eof_frame", {31'd0, frame_o}, 32'd0);
        chk("eof_gnt", {28'd0, gnt_o}, 32'd0);
        chk("eof_valid", {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        int exp;
        rst_i   = 1'b1;
        req_i   = 4'b0000;
        frame_i = 4'b0000;
        valid_i = 4'b0000;
        data_i  = 32'd0;
        tick();
        tick();
        chk("rst_gnt", {28'd0, gnt_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_frame", {31'd0, frame_o}, 32'd0);
        chk("rst_abort", {31'd0, abort_o}, 32'd0);
        chk("rst_trunc", {31'd0, trunc_o}, 32'd0);
        rst_i = 1'b0;

        // Single source, ten bytes
        req_i = 4'b0001;
        tick();
        chk("t1_gnt", {28'd0, gnt_o}, 32'd1);
        req_i = 4'b0000;
        run_frame(0, 10, 0);
        tick();
        chk("t1_gap_frame", {31'd0, frame_o}, 32'd0);
        tick();
        chk("t1_gap_gnt", {28'd0, gnt_o}, 32'd0);

        // All requesting: rotation continues from source 0
        for (int j = 0; j < 5; j++) begin
`ifdef USB_ARB_PRIO0_EN
            exp = 0;
`else
            exp = (1 + j) % 4;
`endif
            req_i = 4'b1111;
            tick();
            chk("t2_gnt", {28'd0, gnt_o}, 32'd1 << exp);
            run_frame(exp, 3, 16 * j);
            if (j == 4) req_i = 4'b0000;
            tick();
            chk("t2_gap1_gnt", {28'd0, gnt_o}, 32'd0);
            chk("t2_gap1_frame", {31'd0, frame_o}, 32'd0);
            tick();
            chk("t2_gap2_gnt", {28'd0, gnt_o}, 32'd0);
            chk("t2_gap2_frame", {31'd0, frame_o}, 32'd0);
        end

        // Source 2 stalls after opening its frame
        req_i = 4'b1100;
        tick();
        chk("t3_gnt", {28'd0, gnt_o}, 32'h4);
        frame_i[2] = 1'b1;
        tick();
        chk("t3_frame", {31'd0, frame_o}, 32'd1);
        repeat (62) tick();
        chk("t3_no_abort", {31'd0, abort_o}, 32'd0);
        chk("t3_frame_held", {31'd0, frame_o}, 32'd1);
        tick();
        chk("t3_abort", {31'd0, abort_o}, 32'd1);
        chk("t3_abort_frame", {31'd0, frame_o}, 32'd0);
        chk("t3_abort_gnt", {28'd0, gnt_o}, 32'd0);
        frame_i[2] = 1'b0;
        req_i = 4'b1000;
        tick();
        chk("t3_abort_pulse", {31'd0, abort_o}, 32'd0);
        tick();
        tick();
        chk("t3_next_gnt", {28'd0, gnt_o}, 32'h8);
        run_frame(3, 2, 8'h40);
        req_i = 4'b0000;
        tick();
        tick();

        // Oversized frame from source 1
        req_i = 4'b0010;
        tick();
        chk("t4_gnt", {28'd0, gnt_o}, 32'h2);
        req_i = 4'b0000;
        run_frame(1, 70, 8'h80);
        tick();
        tick();

        // Reset in the middle of a transfer
        req_i = 4'b0100;
        tick();
        chk("t5_gnt", {28'd0, gnt_o}, 32'h4);
        req_i = 4'b0000;
        frame_i[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            valid_i[2] = 1'b1;
            data_i[23:16] = 8'(8'hA0 + k);
            tick();
            chk("t5_data", {24'd0, data_o}, {24'd0, 8'(8'hA0 + k)});
        end
        rst_i = 1'b1;
        tick();
        chk("t5_rst_gnt", {28'd0, gnt_o}, 32'd0);
        chk("t5_rst_data", {24'd0, data_o}, 32'd0);
        chk("t5_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("t5_rst_frame", {31'd0, frame_o}, 32'd0);
        chk("t5_rst_abort", {31'd0, abort_o}, 32'd0);
        chk("t5_rst_trunc", {31'd0, trunc_o}, 32'd0);
        rst_i = 1'b0;
        frame_i = 4'b0000;
        valid_i = 4'b0000;
        req_i = 4'b1111;
        tick();
        chk("t5_first_gnt", {28'd0, gnt_o}, 32'd1);
        req_i = 4'b0000;
        run_frame(0, 1, 8'h55);
        tick();
        tick();

`ifdef USB_ARB_PRIO0_EN
        // Source 0 dominates; the others rotate among themselves
        req_i = 4'b1111;
        for (int j = 0; j < 2; j++) begin
            tick();
            chk("t6_prio_gnt", {28'd0, gnt_o}, 32'd1);
            run_frame(0, 1, j);
            tick();
            tick();
        end
        req_i = 4'b1110;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t6_rr_gnt", {28'd0, gnt_o}, 32'd1 << (j + 1));
            run_frame(j + 1, 1, j);
            if (j == 2) req_i = 4'b0000;
            tick();
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
